// File: rtl/alu_muldiv_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_exec_pkg
// Shared definitions for the execute stage:
//   - 4-bit operation codes driven by the ALU control decoder
//   - default datapath width
//   - state encoding of the iterative multiply/divide engine
//   - small helpers that classify op codes
// ---------------------------------------------------------------------------
package alu_muldiv_exec_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // MULT/MULTU/DIV/DIVU occupy codes 10xx.
    function automatic logic is_muldiv(input logic [3:0] code);
        return (code[3:2] == 2'b10);
    endfunction

    // Ops that depend on the engine or on HI/LO and therefore must wait.
    function automatic logic is_hilo_op(input logic [3:0] code);
        return is_muldiv(code) || (code == OP_MFHI) || (code == OP_MFLO);
    endfunction

endpackage

// File: rtl/alu_muldiv_exec_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_exec_muldiv_iter
// Iterative 1-bit/cycle multiply / restoring-divide engine.
//   clk_i, rst_i     : clock, asynchronous active-low reset
//   start_i          : accept an operation this edge (only honoured in IDLE)
//   is_signed_i      : signed flavour (MULT/DIV)
//   is_div_i         : divide (1) or multiply (0)
//   src1_i, src2_i   : multiplicand/dividend, multiplier/divisor
//   busy_o           : engine in CALC
//   finish_o         : engine in FINISH; hi_o/lo_o hold the final values
//   done_o           : one-cycle pulse after the FINISH cycle
//   hi_o, lo_o       : sign-corrected results, meaningful while finish_o=1
// Operands are latched as magnitudes; sign fix is applied in FINISH.
// ---------------------------------------------------------------------------
module alu_muldiv_exec_muldiv_iter
    import alu_muldiv_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             finish_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   dividend_q, dividend_d; // raw src1 for divide-by-zero
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rem_shift, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    always_comb begin
        a_neg = is_signed_i & src1_i[WIDTH-1];
        b_neg = is_signed_i & src2_i[WIDTH-1];
        a_mag = a_neg ? -src1_i : src1_i;
        b_mag = b_neg ? -src2_i : src2_i;

        // Shift-add: add multiplicand into the upper half when the
        // multiplier LSB is set, then shift the whole pair right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract.
        // A set MSB of diff means the subtraction went negative.
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, mcand_q};
        div_next  = diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],      acc_q[WIDTH-2:0], 1'b1};

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_CALC;
                    cnt_d      = '0;
                    acc_d      = {{WIDTH{1'b0}}, (is_div_i ? a_mag : b_mag)};
                    mcand_d    = is_div_i ? b_mag : a_mag;
                    dividend_d = src1_i;
                    is_div_d   = is_div_i;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = is_div_i & (src2_i == '0);
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sign correction. Most-negative / -1 falls out naturally: magnitude
    // quotient 2^(W-1) negates to itself and the remainder is zero.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        if (!is_div_q) begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
            hi_o = dividend_q;
            lo_o = '1;
        end else begin
            hi_o = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_o = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy_o   = (state_q == ST_CALC);
    assign finish_o = (state_q == ST_FINISH);
    assign done_o   = done_q;

endmodule

// File: rtl/alu_muldiv_exec.sv
// ---------------------------------------------------------------------------
// alu_muldiv_exec
// Execute stage: combinational ALU, HI/LO registers, stall generation and
// the iterative multiply/divide engine.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   src1_i, src2_i    : register operands (rs, rt)
//   ctrl_i            : 4-bit op code from ALU control
//   valid_i           : instruction in this stage is real
//   result_o, zero_o  : combinational result and its zero flag
//   busy_o, stall_o   : engine iterating / hold upstream stages
//   done_o            : one-cycle pulse after HI/LO update
//   hi_o, lo_o        : HI and LO registers
// ---------------------------------------------------------------------------
module alu_muldiv_exec
    import alu_muldiv_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic             eng_busy, eng_finish, eng_done;
    logic [WIDTH-1:0] eng_hi, eng_lo;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             accept;

    // Engine accepts only when fully idle; a mul/div arriving earlier is
    // held upstream by stall_o until then.
    assign accept = valid_i & is_muldiv(ctrl_i) & ~eng_busy & ~eng_finish;

    alu_muldiv_exec_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (accept),
        .is_signed_i (~ctrl_i[0]),
        .is_div_i    (ctrl_i[1]),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .busy_o      (eng_busy),
        .finish_o    (eng_finish),
        .done_o      (eng_done),
        .hi_o        (eng_hi),
        .lo_o        (eng_lo)
    );

    always_comb begin
        case (ctrl_i)
            OP_AND:  result_o = src1_i & src2_i;
            OP_OR:   result_o = src1_i | src2_i;
            OP_ADD:  result_o = src1_i + src2_i;
            OP_SUB:  result_o = src1_i - src2_i;
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_NOR:  result_o = ~(src1_i | src2_i);
            OP_MFHI: result_o = hi_q;
            OP_MFLO: result_o = lo_q;
            default: result_o = '0;
        endcase
    end

    assign zero_o  = (result_o == '0);
    assign stall_o = valid_i & (eng_busy | eng_finish) & is_hilo_op(ctrl_i);
    assign busy_o  = eng_busy;
    assign done_o  = eng_done;

    always_comb begin
        hi_d = eng_finish ? eng_hi : hi_q;
        lo_d = eng_finish ? eng_lo : lo_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_muldiv_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_exec
// Self-checking bench: combinational ALU table, mul/div results through a
// scoreboard queue (pushed at issue, popped on done_o), stall and reset cases.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_exec;
    import alu_muldiv_exec_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [3:0]   ctrl_i = 4'b0000;
    logic         valid_i = 1'b0;
    logic [W-1:0] result_o, hi_o, lo_o;
    logic         zero_o, busy_o, stall_o, done_o;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    logic [63:0] exp_q[$];

    alu_muldiv_exec #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .ctrl_i   (ctrl_i),
        .valid_i  (valid_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present a mul/div for one cycle; expected {HI,LO} pushed when push=1.
    task automatic issue_md(input logic [3:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic push,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        if (push) exp_q.push_back({exp_hi, exp_lo});
        ctrl_i = c; src1_i = a; src2_i = b; valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        acc_cyc = cyc;
        valid_i = 1'b0; ctrl_i = OP_AND;
        $display("issue ctrl=%b a=%h b=%h at cycle %0d", c, a, b, acc_cyc);
    endtask

    // Wait for done_o, pop the scoreboard and compare HI/LO and latency.
    // HI/LO are written at accept edge + W + 1, so done_o is seen W+1
    // edges after the accept edge.
    task automatic wait_done(input string tag);
        int n;
        logic [63:0] e;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 200);
        if (!done_o) begin
            chk({tag, "_done_timeout"}, 64'(done_o), 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        $display("done %s hi=%h lo=%h latency=%0d", tag, hi_o, lo_o, cyc - acc_cyc);
        chk({tag, "_hi"}, 64'(hi_o), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(lo_o), 64'(e[31:0]));
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(W + 1));
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    endtask

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
    } alu_vec_t;

    alu_vec_t vecs[8];

    initial begin
        int n;
        int dcount;

        vecs[0] = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[1] = '{OP_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[2] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[3] = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[4] = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
        vecs[7] = '{4'b0011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};

        // Reset state
        #1;
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Combinational ALU in IDLE
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            ctrl_i = vecs[i].c; src1_i = vecs[i].a; src2_i = vecs[i].b; valid_i = 1'b1;
            @(negedge clk_i);
            $display("alu ctrl=%b a=%h b=%h result=%h", ctrl_i, src1_i, src2_i, result_o);
            chk("alu_result", 64'(result_o), 64'(vecs[i].r));
            chk("alu_zero", 64'(zero_o), 64'(vecs[i].r == '0));
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;

        // MULT -3 x 5 with unstalled single-cycle ops while busy
        issue_md(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        ctrl_i = OP_ADD; src1_i = 32'd5; src2_i = 32'd3; valid_i = 1'b1;
        @(negedge clk_i);
        $display("busy add result=%h stall=%b busy=%b", result_o, stall_o, busy_o);
        chk("busy_add", 64'(result_o), 64'd8);
        chk("busy_add_stall", 64'(stall_o), 64'd0);
        chk("busy_flag", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        ctrl_i = OP_SUB; src1_i = 32'd3; src2_i = 32'd3;
        @(negedge clk_i);
        $display("busy sub result=%h zero=%b", result_o, zero_o);
        chk("busy_sub_zero", 64'(zero_o), 64'd1);
        @(posedge clk_i); #1;
        ctrl_i = OP_SLT; src1_i = 32'hFFFF_FFFF; src2_i = 32'd1;
        @(negedge clk_i);
        $display("busy slt result=%h", result_o);
        chk("busy_slt", 64'(result_o), 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        wait_done("mult");

        @(posedge clk_i); #1;
        issue_md(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1);
        wait_done("multu");

        @(posedge clk_i); #1;
        issue_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div");

        @(posedge clk_i); #1;
        issue_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        wait_done("div_ovf");

        @(posedge clk_i); #1;
        issue_md(OP_DIVU, 32'd7, 32'd0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF);
        wait_done("divu_zero");

        // MFHI in IDLE returns current HI
        @(posedge clk_i); #1;
        ctrl_i = OP_MFHI; valid_i = 1'b1;
        @(negedge clk_i);
        $display("mfhi result=%h stall=%b", result_o, stall_o);
        chk("mfhi_idle", 64'(result_o), 64'd7);
        chk("mfhi_idle_stall", 64'(stall_o), 64'd0);

        // valid_i=0 never starts the engine
        @(posedge clk_i); #1;
        ctrl_i = OP_MULT; src1_i = 32'd9; src2_i = 32'd9; valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            $display("bubble mult busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);
            chk("bubble_busy", 64'(busy_o), 64'd0);
        end
        chk("bubble_hi", 64'(hi_o), 64'd7);
        chk("bubble_lo", 64'(lo_o), 64'hFFFF_FFFF);

        // MFLO right behind a MULT: stalled through CALC and FINISH
        @(posedge clk_i); #1;
        exp_q.push_back({32'h0000_0000, 32'h0123_4500});
        ctrl_i = OP_MULT; src1_i = 32'h0001_2345; src2_i = 32'h0000_0100; valid_i = 1'b1;
        @(posedge clk_i); #1;
        acc_cyc = cyc;
        ctrl_i = OP_MFLO;
        n = 0;
        do begin
            @(negedge clk_i);
            if (stall_o) n++;
        end while (stall_o && n < 100);
        $display("mflo stall cycles=%0d result=%h done=%b", n, result_o, done_o);
        chk("mflo_stall_len", 64'(n), 64'(W + 1));
        chk("mflo_done", 64'(done_o), 64'd1);
        chk("mflo_new_lo", 64'(result_o), 64'h0123_4500);
        if (exp_q.size() != 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("mflo_mult_hi", 64'(hi_o), 64'(e[63:32]));
            chk("mflo_mult_lo", 64'(lo_o), 64'(e[31:0]));
        end else begin
            chk("mflo_sb_empty", 64'd0, 64'd1);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;

        // Reset in the middle of CALC discards the operation
        issue_md(OP_MULT, 32'd7, 32'd9, 1'b0, '0, '0);
        repeat (9) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        $display("mid-calc reset hi=%h lo=%h busy=%b", hi_o, lo_o, busy_o);
        chk("midrst_hi", 64'(hi_o), 64'd0);
        chk("midrst_lo", 64'(lo_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        dcount = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (done_o) dcount++;
        end
        $display("after reset done pulses=%0d hi=%h lo=%h", dcount, hi_o, lo_o);
        chk("midrst_no_done", 64'(dcount), 64'd0);
        chk("midrst_hi_after", 64'(hi_o), 64'd0);
        chk("midrst_lo_after", 64'(lo_o), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_muldiv_exec.md
Name: alu_muldiv_exec

Overview:
- Execute-stage datapath directly downstream of the ALU control decoder; consumes its 4-bit control code and the two register operands.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) resolve combinationally; MULT/MULTU/DIV/DIVU run on an iterative 1-bit/cycle engine writing HI/LO; MFHI/MFLO read them.
- Raises stall_o so the pipeline/PC holds while the engine is busy.

Parameters:
- WIDTH, 32, operand/result width; engine takes WIDTH iteration cycles.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- src1_i  in  WIDTH  operand A (rs; dividend/multiplicand)
- src2_i  in  WIDTH  operand B (rt; divisor/multiplier)
- ctrl_i  in  4  operation code from ALU control
- valid_i  in  1  instruction in this stage is real (not a bubble)
- result_o  out  WIDTH  combinational result
- zero_o  out  1  result_o == 0
- busy_o  out  1  engine iterating
- stall_o  out  1  hold upstream stages
- done_o  out  1  one-cycle pulse: HI/LO just updated
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_i=0): state IDLE, HI=LO=0, busy_o=0, done_o=0, counter=0; any in-flight operation is discarded and HI/LO are not updated by it.
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1101 MFHI, 1110 MFLO. Other codes give result_o=0.
- ADD/SUB wrap modulo 2^WIDTH with no overflow flag. result_o=0 for mul/div codes.
- Accept: in IDLE with valid_i=1 and a mul/div code, capture the operands and op at edge E0.
  - Signed ops store magnitudes plus the result sign(s).
  - Then go to CALC.
- CALC: WIDTH cycles, one bit per cycle; busy_o=1.
  - Multiply: shift-add.
  - Divide: restoring, remainder/quotient shift.
- FINISH: one cycle; apply sign correction.
  - Signed multiply: negate the 2·WIDTH product if the signs differ.
  - Signed divide: quotient negative if the signs differ; remainder takes the dividend's sign.
  - HI/LO written at edge E0+WIDTH+1; done_o=1 for the following cycle; return to IDLE.
- Results: MULT/MULTU give {HI,LO} = product. DIV/DIVU give LO = quotient, HI = remainder.
- Divide by zero: LO = all-ones, HI = dividend (raw src1_i), no trap.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- stall_o = valid_i & (busy_o | FINISH state) & (code is mul/div/MFHI/MFLO). Non-HI/LO ops proceed unstalled while busy.
- A mul/div presented while busy is not accepted; it is held by the stall and accepted in the first IDLE cycle.
- MFHI/MFLO in IDLE return the current HI/LO combinationally. A mul/div accepted at the same edge does not alter that cycle's result.
- valid_i=0 never starts the engine.

Decomposition:
- Shared package: the 4-bit op-code constants (shared with ALU control), WIDTH default, and state encoding IDLE/CALC/FINISH.
- One sub-module is natural: muldiv_iter (operand latch, counter, shift-add/restoring-divide datapath, sign fix).
- The top module holds the combinational ALU, stall logic and HI/LO registers.

Test Plan:
- Reset mid-CALC: start MULT 7×9, assert rst_i at cycle 10 → HI=LO=0, busy_o=0 immediately, no done_o afterwards.
- MULT -3×5 (0xFFFFFFFD, 5) → done_o at cycle 34 after accept; HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO issued the cycle after a MULT is accepted → stall_o=1 for WIDTH+1 cycles; after done_o, MFLO returns the new LO.
- While busy: ADD 5+3 → result_o=8, stall_o=0. SUB 3-3 → zero_o=1. SLT -1,1 → result_o=1.
- valid_i=0 with code 1000 in IDLE → busy_o stays 0, HI/LO unchanged.
